// File: rtl/complement_to_signmag.sv
`default_nettype none
// ============================================================================
//  Module      : complement_to_signmag
//  Description : Serial two's-complement to sign-magnitude converter.
//                An operand is accepted in IDLE, converted LSB first at
//                one bit per cycle in SHIFT, and the result is held in
//                DONE until the consumer takes it.
//  Ports       :
//     clk        - clock, all state updates on the rising edge
//     rst_n      - asynchronous active-low reset
//     in_valid   - operand present
//     in_ready   - block accepts an operand this cycle (IDLE)
//     operand    - WIDTH-bit two's-complement input
//     out_valid  - result held on sign/magnitude/min_neg (DONE)
//     out_ready  - consumer takes the result
//     sign       - result sign, 1 = negative
//     magnitude  - WIDTH-bit unsigned absolute value
//     min_neg    - operand was the most-negative value
//     busy       - FSM is not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module complement_to_signmag #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign,
   output logic [WIDTH-1:0] magnitude,
   output logic             min_neg,
   output logic             busy
);

   // Counter must reach WIDTH itself: the edge after the last bit registers
   // min_neg and moves to DONE, giving out_valid WIDTH+1 edges after accept.
   localparam int              CW         = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   c_cnt_last = CW'(WIDTH);
   localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_mag;
   logic             r_sign;
   logic             r_seen_one;
   logic             r_min_neg;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_shift_done;
   logic             w_bit;
   logic             w_res_bit;

   assign w_accept     = (r_state == IDLE) && in_valid;
   assign w_shift_done = (r_state == SHIFT) && (r_cnt == c_cnt_last);
   assign w_bit        = r_shift[0];
   // Two's-complement negation done serially: copy bits up to and including
   // the first 1, invert every bit after it. Positive operands pass unchanged.
   assign w_res_bit    = (r_sign && r_seen_one) ? ~w_bit : w_bit;

   assign sign      = r_sign;
   assign magnitude = r_mag;
   assign min_neg   = r_min_neg;

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_next = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (w_shift_done) begin
               w_next = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift    <= '0;
         r_mag      <= '0;
         r_sign     <= 1'b0;
         r_seen_one <= 1'b0;
         r_min_neg  <= 1'b0;
         r_cnt      <= '0;
      end else if (w_accept) begin
         r_shift    <= operand;
         r_mag      <= '0;
         r_sign     <= operand[WIDTH-1];
         r_seen_one <= 1'b0;
         r_min_neg  <= 1'b0;
         r_cnt      <= '0;
      end else if (r_state == SHIFT) begin
         if (!w_shift_done) begin
            // Result bits enter at the MSB so that after WIDTH shifts
            // the first-processed (LSB) bit sits at position 0.
            r_mag      <= {w_res_bit, r_mag[WIDTH-1:1]};
            r_shift    <= {1'b0, r_shift[WIDTH-1:1]};
            r_seen_one <= r_seen_one | w_bit;
            r_cnt      <= r_cnt + CW'(1);
         end else begin
            r_min_neg  <= r_sign && (r_mag == c_min_neg);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_complement_to_signmag.sv
`default_nettype none
// ============================================================================
//  Module      : tb_complement_to_signmag
//  Description : Self-checking bench for complement_to_signmag (WIDTH=32).
//                A cycle-level behavioural model predicts handshake state
//                and arithmetic results; a compare process checks the DUT
//                every cycle, and directed sequences pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_complement_to_signmag;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand;
   logic             out_valid;
   logic             out_ready;
   logic             sign;
   logic [WIDTH-1:0] magnitude;
   logic             min_neg;
   logic             busy;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   complement_to_signmag #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand   (operand),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sign      (sign),
      .magnitude (magnitude),
      .min_neg   (min_neg),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   function automatic logic [31:0] ref_mag(input logic [31:0] v);
      return v[31] ? 32'(-v) : v;
   endfunction

   bit          m_idle    = 1'b1;
   bit          m_done    = 1'b0;
   int          m_cnt     = 0;
   logic [31:0] m_mag     = '0;
   logic        m_sign    = 1'b0;
   logic        m_min     = 1'b0;
   int          m_results = 0;

   // Conversion is modelled purely as "result appears WIDTH+1 edges later".
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle <= 1'b1;
         m_done <= 1'b0;
         m_cnt  <= 0;
      end else if (m_idle) begin
         if (in_valid) begin
            m_idle <= 1'b0;
            m_cnt  <= WIDTH + 1;
            m_sign <= operand[31];
            m_mag  <= ref_mag(operand);
            m_min  <= (operand == 32'h8000_0000);
         end
      end else if (!m_done) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) m_done <= 1'b1;
      end else if (out_ready) begin
         m_done    <= 1'b0;
         m_idle    <= 1'b1;
         m_results <= m_results + 1;
      end
   end

   always @(negedge clk) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_idle});
      chk("busy", {31'd0, busy}, {31'd0, !m_idle});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
      if (m_done) begin
         chk("sign", {31'd0, sign}, {31'd0, m_sign});
         chk("magnitude", magnitude, m_mag);
         chk("min_neg", {31'd0, min_neg}, {31'd0, m_min});
      end
      if (!rst_n) begin
         chk("rst_sign", {31'd0, sign}, 32'd0);
         chk("rst_magnitude", magnitude, 32'd0);
         chk("rst_min_neg", {31'd0, min_neg}, 32'd0);
      end
   end

   // ------------------------------------------------------ directed helpers
   // Called at posedge+1. Presents op, checks latency and literal result,
   // stalls the consumer for `hold` cycles, then handshakes. If chain is set
   // in_valid stays high through the handshake edge with op_next.
   task automatic run_op(input logic [31:0] op, input int hold,
                         input logic [31:0] e_mag, input logic e_sign,
                         input logic e_min, input bit chain,
                         input logic [31:0] op_next,
                         output int acc_edge, output int hs_edge);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      operand  = op;
      @(posedge clk); #1;
      acc_edge = edge_n;
      in_valid = 1'b0;
      operand  = $urandom;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("out_valid_seen", {31'd0, got}, 32'd1);
      chk("latency", 32'(edge_n - acc_edge), 32'd33);
      chk("lit_sign", {31'd0, sign}, {31'd0, e_sign});
      chk("lit_magnitude", magnitude, e_mag);
      chk("lit_min_neg", {31'd0, min_neg}, {31'd0, e_min});
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         operand  = $urandom;
         @(posedge clk); #1;
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_magnitude", magnitude, e_mag);
         chk("hold_sign", {31'd0, sign}, {31'd0, e_sign});
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = chain;
      operand   = op_next;
      out_ready = 1'b1;
      @(posedge clk); #1;
      hs_edge   = edge_n;
      out_ready = 1'b0;
      chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
      chk("hs_busy", {31'd0, busy}, 32'd0);
   endtask

   // ------------------------------------------------------------ stimulus
   int k, h, h_prev, rel_edge, res_before;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      operand   = '0;

      // model pins
      chk("model_neg5", ref_mag(32'hFFFF_FFFB), 32'h0000_0005);
      chk("model_minneg", ref_mag(32'h8000_0000), 32'h8000_0000);
      chk("model_pos", ref_mag(32'h1234_5678), 32'h1234_5678);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      rst_n    = 1'b1;
      rel_edge = edge_n;

      run_op(32'h0000_0005, 0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, '0, k, h);
      chk("first_accept_edge", 32'(k - rel_edge), 32'd1);
      run_op(32'hFFFF_FFFB, 2, 32'h0000_0005, 1'b1, 1'b0, 1'b0, '0, k, h);
      run_op(32'h8000_0000, 0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, '0, k, h);
      run_op(32'h0000_0000, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, '0, k, h);
      run_op(32'hFFFF_FFFF, 10, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, k, h);
      h_prev = h;
      run_op(32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, '0, k, h);
      chk("accept_after_hs", 32'(k - h_prev), 32'd1);

      // reset in the 10th SHIFT cycle
      in_valid = 1'b1;
      operand  = 32'h1234_5678;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      res_before = m_results;
      repeat (9) @(posedge clk);
      #2;
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_magnitude", magnitude, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         chk("abort_no_result", {31'd0, out_valid}, 32'd0);
      end
      chk("abort_no_count", 32'(m_results - res_before), 32'd0);
      run_op(32'hFFFF_FF00, 0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, '0, k, h);

      // randomised back-to-back traffic, model checks every cycle
      res_before = m_results;
      for (int i = 0; i < 1500; i++) begin
         operand   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = $urandom_range(0, 1) == 1;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk("rand_results_enough", {31'd0, (m_results - res_before) >= 20}, 32'd1);
      chk("drain_idle", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
